// File: rtl/cmd_uart_rcv.sv
// 8N1 UART receiver for the follower command path: presents each good byte on cmd
// with a level cmd_rdy flag, and pulses frm_err / overrun on bad stop bits and lost bytes.
module cmd_uart_rcv #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       frm_err,
  output logic       overrun,
  output logic       dbg_state_o
);

  // Handshake: cmd_rdy rises (registered) when a good byte lands in cmd and stays
  // high until a single-cycle clr_cmd_rdy; a completing frame beats a clear in the same cycle.

  localparam int CW = ($clog2(BAUD_CNT + 1) > 12) ? $clog2(BAUD_CNT + 1) : 12;
  localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_CNT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_CNT);
  localparam logic [3:0]    START_IDX = 4'd0;
  localparam logic [3:0]    STOP_IDX  = 4'd9;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          frm_err_q, frm_err_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic          start_smp;
  logic          stop_smp;
  logic          glitch;
  logic          good_frame;
  logic          bad_frame;
  logic [8:0]    shift_nxt;

  // Two-flop synchronizer; both stages reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // A sample is taken in the cycle the down-counter would step from 1 to 0.
  assign tick       = (state_q == RECEIVE) && (baud_q == CW'(1));
  assign start_smp  = tick && (bit_q == START_IDX);
  assign stop_smp   = tick && (bit_q == STOP_IDX);
  assign glitch     = start_smp && rx_s_q;
  assign good_frame = stop_smp && rx_s_q;
  assign bad_frame  = stop_smp && !rx_s_q;
  assign shift_nxt  = {rx_s_q, shift_q[8:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = RECEIVE;
        end
      end
      RECEIVE: begin
        if (glitch || stop_smp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    frm_err_d = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = HALF_BIT;
        bit_d  = 4'd0;
      end
      RECEIVE: begin
        baud_d = baud_q - CW'(1);
        if (tick) begin
          baud_d = FULL_BIT;
          bit_d  = bit_q + 4'd1;
          if (!glitch) begin
            shift_d = shift_nxt;
          end
        end
      end
      default: begin
        baud_d = HALF_BIT;
        bit_d  = 4'd0;
      end
    endcase

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    // At the stop sample, shift_nxt[7:0] holds data bits 0..7 with the start bit shifted out.
    if (good_frame) begin
      cmd_d     = shift_nxt[7:0];
      cmd_rdy_d = 1'b1;
      overrun_d = cmd_rdy_q && !clr_cmd_rdy;
    end

    if (bad_frame) begin
      frm_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= HALF_BIT;
      bit_q     <= 4'd0;
      shift_q   <= 9'd0;
      cmd_q     <= 8'h00;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign frm_err     = frm_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/cmd_uart_rcv.md
# cmd_uart_rcv

Serial front end for the follower's command path. It receives 8N1 UART frames on `RX` and presents each good byte as `cmd[7:0]` with a level `cmd_rdy` flag. `cmd_rdy` holds until the command controller acknowledges with a `clr_cmd_rdy` pulse. It is the responder side of the `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake: it rejects false starts and flags framing errors and overruns.

## Interface
- `BAUD_CNT`, default 2604: clocks per bit (50 MHz / 19200 baud); must be even and ≥ 8.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `RX`  in  1  asynchronous serial line; idles high.
- `clr_cmd_rdy`  in  1  single-cycle acknowledge from the controller.
- `cmd`  out  8  last good received byte, LSB first on the wire.
- `cmd_rdy`  out  1  level: a new unacknowledged byte is in `cmd`.
- `frm_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte lands while `cmd_rdy` is still high.

## Operation
- Synchronizer:
  - `RX` passes through two flops, both reset to 1, to give `rx_s`.
  - All logic uses only `rx_s`.
- State machine: `IDLE`, `RECEIVE`; resets to `IDLE`.
- `IDLE`:
  - When `rx_s == 0`, go to `RECEIVE`.
  - Load the 12-bit (or wider) baud down-counter with `BAUD_CNT/2`.
  - Clear the 4-bit bit counter.
- `RECEIVE`:
  - Baud counter decrements each clock.
  - When it reaches 0, take a sample: shift `rx_s` into the MSB of a 9-bit right-shift register, increment the bit counter, and reload with `BAUD_CNT`.
- Sample 0 is the start bit:
  - If the start sample is 1, it is a glitch: return to `IDLE`.
  - The glitch leaves no pulse and no register change.
- Samples 1–8 are the data bits, LSB first. Sample 9 is the stop bit.
- After sample 9, return to `IDLE` the same cycle.
- If the stop bit is 1 (good frame):
  - `cmd` ← data bits.
  - `cmd_rdy` ← 1.
  - If `cmd_rdy` was already 1 and not being cleared that cycle, pulse `overrun`. `cmd` is overwritten with the new byte.
- If the stop bit is 0:
  - Pulse `frm_err`.
  - `cmd` and `cmd_rdy` are unchanged.
- `cmd` changes only on good-frame completion. It is stable whenever `cmd_rdy` is high and no new frame completes.
- `clr_cmd_rdy` clears `cmd_rdy` on the next edge.
- Good-frame completion and `clr_cmd_rdy` in the same cycle: set wins, and `cmd_rdy` stays 1 with no `overrun` pulse.
- A new frame may begin in `IDLE` the cycle after stop-bit sampling. No extra idle time is required beyond the line being low.

## Timing
- Reset values:
  - `cmd` = 0x00, `cmd_rdy` = 0, `frm_err` = 0, `overrun` = 0.
  - State `IDLE`; sync flops = 1.
- Latency:
  - `RX` falling to `rx_s` low: 2 clocks.
  - `rx_s` low seen in `IDLE` (cycle T) to start sample: cycle T + `BAUD_CNT/2`.
  - Sample k occurs at T + `BAUD_CNT/2` + k·`BAUD_CNT`.
- `cmd`, `cmd_rdy`, `frm_err`, `overrun` update registered, one clock after the stop-bit sample.
  - That is cycle T + `BAUD_CNT/2` + 9·`BAUD_CNT` + 1.
- `frm_err` and `overrun` are high exactly one clock.
- All outputs are registered; none depend combinationally on inputs.
- Reset mid-frame: everything returns to reset values immediately. After release, the FSM needs `rx_s` low in `IDLE` to start.
  - A line still low at release starts a frame. It is then handled as a normal frame and is likely rejected or errored.

## Test plan
- `BAUD_CNT`=16, send 0xA5 with a good stop bit:
  - `cmd_rdy` rises exactly 153 clocks after `rx_s` falls.
  - `cmd`=0xA5, no pulses.
- After 0xA5, pulse `clr_cmd_rdy`:
  - `cmd_rdy`=0 next clock.
  - `cmd` holds 0xA5.
- Send 0x40, then 0x3C without clearing:
  - `cmd`=0x3C, `cmd_rdy` stays 1.
  - One-cycle `overrun`.
  - Repeat with `clr_cmd_rdy` asserted on the completion cycle: no `overrun`.
- Send 0x7E with the stop bit driven low:
  - `frm_err` pulses once.
  - `cmd` and `cmd_rdy` unchanged.
  - A following good 0x81 is received normally.
- Drive `RX` low for 4 clocks, then high:
  - FSM returns to `IDLE` after the start sample.
  - No output change.
  - A subsequent 0x55 is received correctly.
- Assert `rst_n` low at data bit 4 of a frame:
  - All outputs return to 0.
  - A clean 0xC3 frame after release gives `cmd`=0xC3, `cmd_rdy`=1.
